pdp8_mem_ctrl: RTL and testbench
================================

PDP8_MEM_CTRL -- requirements
Module: pdp8_mem_ctrl

Interface
REQ-001 SHALL have parameter-free widths from macros: ADDR_WIDTH (12), DATA_WIDTH (12); memory depth 2**ADDR_WIDTH words.
REQ-002 SHALL have port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset_n  in  1  synchronous, active-low reset.
REQ-004 SHALL have ports: ifu_rd_req  in  1  fetch read request pulse; ifu_rd_addr  in  ADDR_WIDTH  fetch address.
REQ-005 SHALL have ports: ifu_rd_data  out  DATA_WIDTH  fetch read data; ifu_rd_valid  out  1  one-cycle data-valid pulse.
REQ-006 SHALL have ports: exec_rd_req  in  1; exec_rd_addr  in  ADDR_WIDTH; exec_rd_data  out  DATA_WIDTH; exec_rd_valid  out  1 (execute-unit read, same semantics as fetch).
REQ-007 SHALL have ports: exec_wr_req  in  1; exec_wr_addr  in  ADDR_WIDTH; exec_wr_data  in  DATA_WIDTH (execute-unit write).
REQ-008 SHALL have ports: mem_busy  out  1  any request pending; ovf_err  out  3  sticky overflow flags {wr, exec_rd, ifu}.

Function
REQ-009 SHALL contain one single-port array, one access (read or write) per cycle.
REQ-010 SHALL sample each *_req at every edge; sampled request SHALL load that port's one-deep holding register (pending bit, address, write data).
REQ-011 SHALL select each cycle, combinationally from pending bits, one port: exec_wr > exec_rd > ifu_rd, except REQ-012.
REQ-012 SHALL keep a 2-bit ifu age counter: increments each cycle ifu pending and not granted, saturates at 3, clears when granted or not pending; at value 3 ifu SHALL take top priority.
REQ-013 SHALL perform the granted access at the next edge and clear that port's pending bit at that edge.
REQ-014 Read latency: request sampled at edge E, uncontended -> data and *_rd_valid visible after edge E+1, valid high exactly one cycle.
REQ-015 *_rd_data SHALL hold last returned value until next valid for that port.
REQ-016 Write SHALL update array at grant edge; a read granted on a later edge to same address SHALL return new data.
REQ-017 New request on a port whose pending entry is granted at the same edge SHALL be accepted (no overflow).
REQ-018 New request on a port whose pending entry is not granted at that edge SHALL be dropped, pending entry kept unchanged, and that port's ovf_err bit set.
REQ-019 Simultaneous requests on all three ports SHALL all be accepted if none pending; served over three consecutive grant edges in priority order.
REQ-020 mem_busy SHALL equal OR of pending bits (registered state, combinational output).

Reset
REQ-021 reset_n low at an edge SHALL clear pending bits, age counter, *_rd_valid, *_rd_data, ovf_err; mem_busy 0 next cycle.
REQ-022 Requests sampled during reset SHALL be discarded; in-flight accesses abandoned; no array write SHALL occur.
REQ-023 Array contents SHALL NOT be cleared by reset.

Configuration
REQ-024 Macro MEM_STATS_EN defined: SHALL add outputs ifu_rd_cnt, exec_rd_cnt, exec_wr_cnt (16 bits each), incrementing on each grant of that port, saturating at 0xFFFF, cleared by reset.
REQ-025 MEM_STATS_EN undefined: those ports and counters SHALL be absent; all other behaviour identical.

Verification
REQ-026 Write 0o1234 to 0o0200, then ifu read 0o0200 -> ifu_rd_valid one cycle, ifu_rd_data = 0o1234, 2-cycle latency.
REQ-027 exec_wr, exec_rd, ifu_rd pulsed same edge, idle controller -> grants wr, exec_rd, ifu on three consecutive edges; exec_rd_valid precedes ifu_rd_valid by one cycle.
REQ-028 exec_rd_req held high 5 cycles with ifu pending -> ifu granted no later than 3rd waiting cycle (aging); exec reads overflow per REQ-018.
REQ-029 exec_wr held high while exec_rd pending -> ovf_err = 3'b000 for wr (granted each edge), exec_rd waits; second ifu_rd_req while ifu pending and not granted -> ovf_err[0]=1, sticky.
REQ-030 reset_n low one edge with all three pending -> mem_busy 0, no valid pulses, ovf_err 0, addressed word unchanged; with MEM_STATS_EN, counters 0.

Source files
------------

// File: rtl/pdp8_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pdp8_mem_ctrl
// Brief    : Three-port arbiter in front of a single-port PDP-8 core memory.
//            Fetch read, execute read and execute write each have a one-deep
//            holding register. A 2-bit age counter stops the fetch port from
//            being starved by a busy execute unit.
//            Optional macro MEM_STATS_EN adds saturating per-port grant counters.
// Revision : 1.0 - initial release
// ============================================================================

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 12
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 12
`endif

module pdp8_mem_ctrl (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   ifu_rd_req,
    input  logic [`ADDR_WIDTH-1:0] ifu_rd_addr,
    output logic [`DATA_WIDTH-1:0] ifu_rd_data,
    output logic                   ifu_rd_valid,
    input  logic                   exec_rd_req,
    input  logic [`ADDR_WIDTH-1:0] exec_rd_addr,
    output logic [`DATA_WIDTH-1:0] exec_rd_data,
    output logic                   exec_rd_valid,
    input  logic                   exec_wr_req,
    input  logic [`ADDR_WIDTH-1:0] exec_wr_addr,
    input  logic [`DATA_WIDTH-1:0] exec_wr_data,
    output logic                   mem_busy,
    output logic [2:0]             ovf_err
`ifdef MEM_STATS_EN
    ,
    output logic [15:0]            ifu_rd_cnt,
    output logic [15:0]            exec_rd_cnt,
    output logic [15:0]            exec_wr_cnt
`endif
);

    localparam int unsigned c_addr_w  = `ADDR_WIDTH;
    localparam int unsigned c_data_w  = `DATA_WIDTH;
    localparam int unsigned c_depth   = 2 ** c_addr_w;
    localparam logic [1:0]  c_age_max = 2'd3;

    // Storage array: deliberately not reset so core contents survive reset
    logic [c_data_w-1:0] mem_q [c_depth];

    // Holding registers
    logic                ifu_pend_q, ifu_pend_d;
    logic [c_addr_w-1:0] ifu_addr_q, ifu_addr_d;
    logic                rd_pend_q,  rd_pend_d;
    logic [c_addr_w-1:0] rd_addr_q,  rd_addr_d;
    logic                wr_pend_q,  wr_pend_d;
    logic [c_addr_w-1:0] wr_addr_q,  wr_addr_d;
    logic [c_data_w-1:0] wr_data_q,  wr_data_d;
    logic [1:0]          age_q,      age_d;
    logic [2:0]          ovf_q,      ovf_d;

    // Read return registers
    logic                ifu_rd_valid_q,  ifu_rd_valid_d;
    logic [c_data_w-1:0] ifu_rd_data_q,   ifu_rd_data_d;
    logic                exec_rd_valid_q, exec_rd_valid_d;
    logic [c_data_w-1:0] exec_rd_data_q,  exec_rd_data_d;

    // Arbitration and array access
    logic                gnt_ifu, gnt_rd, gnt_wr;
    logic [c_addr_w-1:0] mem_addr;
    logic [c_data_w-1:0] mem_rdata;
    logic                mem_we;

    // Pick one pending port: an aged fetch wins, otherwise write > exec read > fetch
    always_comb begin
        gnt_ifu = 1'b0;
        gnt_rd  = 1'b0;
        gnt_wr  = 1'b0;
        if (ifu_pend_q && (age_q == c_age_max)) begin
            gnt_ifu = 1'b1;
        end else if (wr_pend_q) begin
            gnt_wr = 1'b1;
        end else if (rd_pend_q) begin
            gnt_rd = 1'b1;
        end else if (ifu_pend_q) begin
            gnt_ifu = 1'b1;
        end
    end

    // Route the granted port onto the single array port
    always_comb begin
        mem_addr  = ifu_addr_q;
        if (gnt_wr) begin
            mem_addr = wr_addr_q;
        end else if (gnt_rd) begin
            mem_addr = rd_addr_q;
        end
        mem_rdata = mem_q[mem_addr];
        mem_we    = gnt_wr && reset_n;
    end

    // Array write at the grant edge; suppressed while reset is asserted
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_addr] <= wr_data_q;
        end
    end

    // Next state: accept into a free (or freed-this-edge) slot, otherwise drop and flag
    always_comb begin
        ifu_pend_d = ifu_pend_q & ~gnt_ifu;
        ifu_addr_d = ifu_addr_q;
        rd_pend_d  = rd_pend_q & ~gnt_rd;
        rd_addr_d  = rd_addr_q;
        wr_pend_d  = wr_pend_q & ~gnt_wr;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        ovf_d      = ovf_q;

        if (ifu_rd_req) begin
            if (!ifu_pend_q || gnt_ifu) begin
                ifu_pend_d = 1'b1;
                ifu_addr_d = ifu_rd_addr;
            end else begin
                ovf_d[0] = 1'b1;
            end
        end
        if (exec_rd_req) begin
            if (!rd_pend_q || gnt_rd) begin
                rd_pend_d = 1'b1;
                rd_addr_d = exec_rd_addr;
            end else begin
                ovf_d[1] = 1'b1;
            end
        end
        if (exec_wr_req) begin
            if (!wr_pend_q || gnt_wr) begin
                wr_pend_d = 1'b1;
                wr_addr_d = exec_wr_addr;
                wr_data_d = exec_wr_data;
            end else begin
                ovf_d[2] = 1'b1;
            end
        end

        // Age counts only cycles the fetch spends waiting behind other ports
        if (!ifu_pend_q || gnt_ifu) begin
            age_d = 2'd0;
        end else if (age_q != c_age_max) begin
            age_d = age_q + 2'd1;
        end else begin
            age_d = age_q;
        end

        ifu_rd_valid_d  = gnt_ifu;
        ifu_rd_data_d   = gnt_ifu ? mem_rdata : ifu_rd_data_q;
        exec_rd_valid_d = gnt_rd;
        exec_rd_data_d  = gnt_rd ? mem_rdata : exec_rd_data_q;
    end

    // Control and return-path registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ifu_pend_q      <= 1'b0;
            ifu_addr_q      <= '0;
            rd_pend_q       <= 1'b0;
            rd_addr_q       <= '0;
            wr_pend_q       <= 1'b0;
            wr_addr_q       <= '0;
            wr_data_q       <= '0;
            age_q           <= 2'd0;
            ovf_q           <= 3'b000;
            ifu_rd_valid_q  <= 1'b0;
            ifu_rd_data_q   <= '0;
            exec_rd_valid_q <= 1'b0;
            exec_rd_data_q  <= '0;
        end else begin
            ifu_pend_q      <= ifu_pend_d;
            ifu_addr_q      <= ifu_addr_d;
            rd_pend_q       <= rd_pend_d;
            rd_addr_q       <= rd_addr_d;
            wr_pend_q       <= wr_pend_d;
            wr_addr_q       <= wr_addr_d;
            wr_data_q       <= wr_data_d;
            age_q           <= age_d;
            ovf_q           <= ovf_d;
            ifu_rd_valid_q  <= ifu_rd_valid_d;
            ifu_rd_data_q   <= ifu_rd_data_d;
            exec_rd_valid_q <= exec_rd_valid_d;
            exec_rd_data_q  <= exec_rd_data_d;
        end
    end

    assign ifu_rd_valid  = ifu_rd_valid_q;
    assign ifu_rd_data   = ifu_rd_data_q;
    assign exec_rd_valid = exec_rd_valid_q;
    assign exec_rd_data  = exec_rd_data_q;
    assign ovf_err       = ovf_q;
    assign mem_busy      = ifu_pend_q | rd_pend_q | wr_pend_q;

`ifdef MEM_STATS_EN
    logic [15:0] ifu_cnt_q, ifu_cnt_d;
    logic [15:0] rd_cnt_q,  rd_cnt_d;
    logic [15:0] wr_cnt_q,  wr_cnt_d;

    // Saturating grant counters
    always_comb begin
        ifu_cnt_d = ifu_cnt_q + {15'd0, (gnt_ifu && (ifu_cnt_q != 16'hFFFF))};
        rd_cnt_d  = rd_cnt_q  + {15'd0, (gnt_rd  && (rd_cnt_q  != 16'hFFFF))};
        wr_cnt_d  = wr_cnt_q  + {15'd0, (gnt_wr  && (wr_cnt_q  != 16'hFFFF))};
    end

    // Counter registers, cleared by reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ifu_cnt_q <= 16'd0;
            rd_cnt_q  <= 16'd0;
            wr_cnt_q  <= 16'd0;
        end else begin
            ifu_cnt_q <= ifu_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
        end
    end

    assign ifu_rd_cnt  = ifu_cnt_q;
    assign exec_rd_cnt = rd_cnt_q;
    assign exec_wr_cnt = wr_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pdp8_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pdp8_mem_ctrl
// Brief    : Scoreboard bench for pdp8_mem_ctrl. Stimulus pushes expected read
//            data and arrival cycle; a negedge monitor pops on each valid.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pdp8_mem_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ifu_rd_req, exec_rd_req, exec_wr_req;
    logic [11:0] ifu_rd_addr, exec_rd_addr, exec_wr_addr, exec_wr_data;
    logic [11:0] ifu_rd_data, exec_rd_data;
    logic        ifu_rd_valid, exec_rd_valid, mem_busy;
    logic [2:0]  ovf_err;
`ifdef MEM_STATS_EN
    logic [15:0] ifu_rd_cnt, exec_rd_cnt, exec_wr_cnt;
`endif

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        logic [11:0] data;
        int          cyc;
    } exp_t;

    exp_t ifu_q[$];
    exp_t rd_q[$];

    pdp8_mem_ctrl dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .ifu_rd_req    (ifu_rd_req),
        .ifu_rd_addr   (ifu_rd_addr),
        .ifu_rd_data   (ifu_rd_data),
        .ifu_rd_valid  (ifu_rd_valid),
        .exec_rd_req   (exec_rd_req),
        .exec_rd_addr  (exec_rd_addr),
        .exec_rd_data  (exec_rd_data),
        .exec_rd_valid (exec_rd_valid),
        .exec_wr_req   (exec_wr_req),
        .exec_wr_addr  (exec_wr_addr),
        .exec_wr_data  (exec_wr_data),
        .mem_busy      (mem_busy),
        .ovf_err       (ovf_err)
`ifdef MEM_STATS_EN
        ,
        .ifu_rd_cnt    (ifu_rd_cnt),
        .exec_rd_cnt   (exec_rd_cnt),
        .exec_wr_cnt   (exec_wr_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0o required %0o (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every valid pulse must match the head of its port's queue
    always @(negedge clk) begin
        exp_t e;
        if (ifu_rd_valid) begin
            if (ifu_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL ifu_unexpected_valid: got valid data %0o required no valid (cycle %0d)", ifu_rd_data, cyc);
            end else begin
                e = ifu_q.pop_front();
                check("ifu_data", {20'd0, ifu_rd_data}, {20'd0, e.data});
                check("ifu_cycle", cyc, e.cyc);
            end
        end
        if (exec_rd_valid) begin
            if (rd_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL exec_unexpected_valid: got valid data %0o required no valid (cycle %0d)", exec_rd_data, cyc);
            end else begin
                e = rd_q.pop_front();
                check("exec_data", {20'd0, exec_rd_data}, {20'd0, e.data});
                check("exec_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push_ifu(input logic [11:0] d, input int c);
        exp_t e;
        e.data = d;
        e.cyc  = c;
        ifu_q.push_back(e);
    endtask

    task automatic push_rd(input logic [11:0] d, input int c);
        exp_t e;
        e.data = d;
        e.cyc  = c;
        rd_q.push_back(e);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((mem_busy || ifu_q.size() != 0 || rd_q.size() != 0) && n < 40) begin
            tick();
            n++;
        end
        check("idle_within_budget", {31'd0, (n < 40)}, 32'd1);
        tick();
    endtask

    task automatic exec_write(input logic [11:0] a, input logic [11:0] d);
        exec_wr_req  = 1'b1;
        exec_wr_addr = a;
        exec_wr_data = d;
        tick();
        exec_wr_req  = 1'b0;
        wait_idle();
    endtask

    task automatic exec_read(input logic [11:0] a, input logic [11:0] exp);
        push_rd(exp, cyc + 2);
        exec_rd_req  = 1'b1;
        exec_rd_addr = a;
        tick();
        exec_rd_req  = 1'b0;
        wait_idle();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish required finish before time limit");
        $fatal(1);
    end

    initial begin
        int m;
        reset_n      = 1'b0;
        ifu_rd_req   = 1'b0;
        exec_rd_req  = 1'b0;
        exec_wr_req  = 1'b0;
        ifu_rd_addr  = '0;
        exec_rd_addr = '0;
        exec_wr_addr = '0;
        exec_wr_data = '0;

        // Reset state
        repeat (3) tick();
        check("rst_busy", {31'd0, mem_busy}, 32'd0);
        check("rst_ovf", {29'd0, ovf_err}, 32'd0);
        check("rst_ifu_valid", {31'd0, ifu_rd_valid}, 32'd0);
        check("rst_exec_valid", {31'd0, exec_rd_valid}, 32'd0);
        check("rst_ifu_data", {20'd0, ifu_rd_data}, 32'd0);
        reset_n = 1'b1;
        tick();

        // Write 0o1234 @0o0200 then fetch it back with 2-cycle latency
        m = cyc;
        exec_wr_req  = 1'b1;
        exec_wr_addr = 12'o0200;
        exec_wr_data = 12'o1234;
        tick();
        exec_wr_req  = 1'b0;
        ifu_rd_req   = 1'b1;
        ifu_rd_addr  = 12'o0200;
        push_ifu(12'o1234, m + 3);
        tick();
        ifu_rd_req   = 1'b0;
        check("busy_while_pending", {31'd0, mem_busy}, 32'd1);
        wait_idle();
        check("ifu_data_held", {20'd0, ifu_rd_data}, 32'o1234);
        check("idle_busy", {31'd0, mem_busy}, 32'd0);

        // All three ports at once: wr, then exec read, then fetch
        m = cyc;
        exec_wr_req  = 1'b1;
        exec_wr_addr = 12'o0300;
        exec_wr_data = 12'o4321;
        exec_rd_req  = 1'b1;
        exec_rd_addr = 12'o0200;
        ifu_rd_req   = 1'b1;
        ifu_rd_addr  = 12'o0300;
        push_rd(12'o1234, m + 3);
        push_ifu(12'o4321, m + 4);
        tick();
        exec_wr_req  = 1'b0;
        exec_rd_req  = 1'b0;
        ifu_rd_req   = 1'b0;
        wait_idle();
        check("ovf_after_triple", {29'd0, ovf_err}, 32'd0);

        // Aging: exec read held for 5 edges while fetch waits
        exec_write(12'o0400, 12'o0555);
        exec_write(12'o0401, 12'o0666);
        m = cyc;
        ifu_rd_req   = 1'b1;
        ifu_rd_addr  = 12'o0401;
        exec_rd_req  = 1'b1;
        exec_rd_addr = 12'o0400;
        push_rd(12'o0555, m + 2);
        push_rd(12'o0555, m + 3);
        push_rd(12'o0555, m + 4);
        push_ifu(12'o0666, m + 5);
        push_rd(12'o0555, m + 6);
        tick();
        ifu_rd_req   = 1'b0;
        repeat (4) tick();
        exec_rd_req  = 1'b0;
        wait_idle();
        check("ovf_exec_rd", {29'd0, ovf_err}, 32'b010);

        // Held write is granted every edge; second fetch while waiting overflows
        m = cyc;
        exec_wr_req  = 1'b1;
        exec_wr_addr = 12'o0500;
        exec_wr_data = 12'o1111;
        exec_rd_req  = 1'b1;
        exec_rd_addr = 12'o0401;
        ifu_rd_req   = 1'b1;
        ifu_rd_addr  = 12'o0400;
        push_ifu(12'o0555, m + 5);
        push_rd(12'o0666, m + 6);
        tick();
        exec_rd_req  = 1'b0;
        ifu_rd_addr  = 12'o0777;
        exec_wr_addr = 12'o0501;
        exec_wr_data = 12'o2222;
        tick();
        ifu_rd_req   = 1'b0;
        exec_wr_addr = 12'o0502;
        exec_wr_data = 12'o3333;
        tick();
        exec_wr_req  = 1'b0;
        wait_idle();
        check("ovf_ifu_sticky", {29'd0, ovf_err}, 32'b011);
        exec_read(12'o0500, 12'o1111);
        exec_read(12'o0501, 12'o2222);
        exec_read(12'o0502, 12'o3333);
        check("ovf_still_sticky", {29'd0, ovf_err}, 32'b011);

        // Reset with all three pending; the write during reset must be discarded
        exec_wr_req  = 1'b1;
        exec_wr_addr = 12'o0200;
        exec_wr_data = 12'o7070;
        exec_rd_req  = 1'b1;
        exec_rd_addr = 12'o0300;
        ifu_rd_req   = 1'b1;
        ifu_rd_addr  = 12'o0301;
        tick();
        check("busy_before_reset", {31'd0, mem_busy}, 32'd1);
        exec_rd_req  = 1'b0;
        ifu_rd_req   = 1'b0;
        exec_wr_data = 12'o6060;
        reset_n      = 1'b0;
        tick();
        reset_n      = 1'b1;
        exec_wr_req  = 1'b0;
        check("post_rst_busy", {31'd0, mem_busy}, 32'd0);
        check("post_rst_ovf", {29'd0, ovf_err}, 32'd0);
        check("post_rst_exec_data", {20'd0, exec_rd_data}, 32'd0);
        check("post_rst_ifu_data", {20'd0, ifu_rd_data}, 32'd0);
`ifdef MEM_STATS_EN
        check("post_rst_cnt_ifu", {16'd0, ifu_rd_cnt}, 32'd0);
        check("post_rst_cnt_rd", {16'd0, exec_rd_cnt}, 32'd0);
        check("post_rst_cnt_wr", {16'd0, exec_wr_cnt}, 32'd0);
`endif
        repeat (4) tick();
        check("post_rst_still_idle", {31'd0, mem_busy}, 32'd0);
        exec_read(12'o0200, 12'o1234);

        check("queues_drained", ifu_q.size() + rd_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
